// File: rtl/nes_cpu_pkg.sv
// Shared types and helpers for the NES CPU front end.
// Holds the assembler state enum, the fetch buffer entry and the opcode length table.
package nes_cpu_pkg;

    localparam int MEM_ADDR_SIZE = 16;

    typedef enum logic [1:0] {
        ASM_OPC,
        ASM_OP1,
        ASM_OP2,
        ASM_EMIT
    } asm_state_e;

    typedef struct packed {
        logic [7:0]               data;
        logic [MEM_ADDR_SIZE-1:0] addr;
    } fetch_entry_t;

    // Instruction length in bytes for official 6502 opcodes; illegal ones are 1.
    function automatic logic [1:0] opcode_len(input logic [7:0] op);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = op[7:4];
        lo = op[3:0];
        opcode_len = 2'd1;
        case (lo)
            4'h0: begin
                if (hi[0])
                    opcode_len = 2'd2;
                else if (hi == 4'h2)
                    opcode_len = 2'd3;
                else if (hi >= 4'hA)
                    opcode_len = 2'd2;
            end
            4'h1, 4'h5, 4'h6: opcode_len = 2'd2;
            4'h2: if (op == 8'hA2) opcode_len = 2'd2;
            4'h4: begin
                if (op == 8'h24 || op == 8'h84 || op == 8'hA4 ||
                    op == 8'hC4 || op == 8'hE4 || op == 8'h94 ||
                    op == 8'hB4)
                    opcode_len = 2'd2;
            end
            4'h9: begin
                if (hi[0])
                    opcode_len = 2'd3;
                else if (op != 8'h89)
                    opcode_len = 2'd2;
            end
            4'hC: begin
                if (op == 8'h2C || op == 8'h4C || op == 8'h6C ||
                    op == 8'h8C || op == 8'hAC || op == 8'hCC ||
                    op == 8'hEC || op == 8'hBC)
                    opcode_len = 2'd3;
            end
            4'hD: opcode_len = 2'd3;
            4'hE: if (op != 8'h9E) opcode_len = 2'd3;
            default: opcode_len = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Byte+address buffer between instruction memory and the assembler.
// Synchronous push/pop with flush; the caller never pushes when full.
module fetch_fifo
    import nes_cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;

    assign head_o  = r_mem[r_rd];
    assign empty_o = (r_count == '0);
    assign count_o = r_count;

    // Pointer and occupancy bookkeeping; flush discards everything.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (push_i)
                r_wr <= r_wr + PTR_ONE;
            if (pop_i)
                r_rd <= r_rd + PTR_ONE;
            unique case ({push_i, pop_i})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage written at the tail.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (push_i && !flush_i) begin
            r_mem[r_wr] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// 6502 instruction fetch: byte reads at the PC, buffering, 1-3 byte assembly.
// Optional NES_FETCH_PERF_EN adds accepted-instruction and stall counters.
module fetch_unit
    import nes_cpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = MEM_ADDR_SIZE
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              taken_branch_o,
    output logic [ADDR_W-1:0] new_pc_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [7:0]        instr_opcode_o,
    output logic [15:0]       instr_operand_o,
    output logic [1:0]        instr_len_o,
    output logic [ADDR_W-1:0] instr_pc_o
`ifdef NES_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_instr_o,
    output logic [31:0]       perf_stall_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic              r_inflight;
    logic [ADDR_W-1:0] r_req_addr;
    asm_state_e        r_state;
    asm_state_e        w_next;
    logic [7:0]        r_opcode;
    logic [15:0]       r_operand;
    logic [1:0]        r_len;
    logic [ADDR_W-1:0] r_pc;

    logic [CW-1:0]     w_count;
    logic [CW:0]       w_used;
    logic              w_credit;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;

    assign w_used     = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_credit   = (w_used < DEPTH_C);
    assign mem_addr_o = pc_i;

    // Issue: redirect beats a new read; without credit the PC is held.
    always_comb begin
        mem_req_o      = 1'b0;
        taken_branch_o = 1'b0;
        new_pc_o       = '0;
        if (rstn_i) begin
            if (redirect_i) begin
                taken_branch_o = 1'b1;
                new_pc_o       = redirect_pc_i;
            end else if (w_credit) begin
                mem_req_o = 1'b1;
            end else begin
                taken_branch_o = 1'b1;
                new_pc_o       = pc_i;
            end
        end
    end

    // Track the single outstanding read and its address.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_inflight <= 1'b0;
            r_req_addr <= '0;
        end else begin
            r_inflight <= mem_req_o;
            if (mem_req_o)
                r_req_addr <= pc_i;
        end
    end

    assign w_push            = r_inflight && !redirect_i;
    assign w_push_entry.data = mem_rdata_i;
    assign w_push_entry.addr = r_req_addr;
    assign w_pop = !redirect_i && !w_empty && (r_state != ASM_EMIT);

    fetch_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .push_i      (w_push),
        .push_data_i (w_push_entry),
        .pop_i       (w_pop),
        .flush_i     (redirect_i),
        .head_o      (w_head),
        .empty_o     (w_empty),
        .count_o     (w_count)
    );

    // Assembler state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_state <= ASM_OPC;
        else
            r_state <= w_next;
    end

    // Assembler next state and valid; redirect always returns to ASM_OPC.
    always_comb begin
        w_next        = r_state;
        instr_valid_o = (r_state == ASM_EMIT);
        unique case (r_state)
            ASM_OPC:
                if (w_pop)
                    w_next = (opcode_len(w_head.data) == 2'd1) ? ASM_EMIT : ASM_OP1;
            ASM_OP1:
                if (w_pop)
                    w_next = (r_len == 2'd2) ? ASM_EMIT : ASM_OP2;
            ASM_OP2:
                if (w_pop)
                    w_next = ASM_EMIT;
            ASM_EMIT:
                if (instr_ready_i)
                    w_next = ASM_OPC;
            default:
                w_next = ASM_OPC;
        endcase
        if (redirect_i)
            w_next = ASM_OPC;
    end

    // Latch opcode fields and operand bytes as they are popped.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_opcode  <= '0;
            r_operand <= '0;
            r_len     <= '0;
            r_pc      <= '0;
        end else if (w_pop) begin
            unique case (r_state)
                ASM_OPC: begin
                    r_opcode  <= w_head.data;
                    r_pc      <= w_head.addr;
                    r_len     <= opcode_len(w_head.data);
                    r_operand <= '0;
                end
                ASM_OP1: r_operand[7:0]  <= w_head.data;
                ASM_OP2: r_operand[15:8] <= w_head.data;
                default: r_operand <= r_operand;
            endcase
        end
    end

    assign instr_opcode_o  = r_opcode;
    assign instr_operand_o = r_operand;
    assign instr_len_o     = r_len;
    assign instr_pc_o      = r_pc;

`ifdef NES_FETCH_PERF_EN
    logic w_accept;
    logic w_stall;

    assign w_accept = instr_valid_o && instr_ready_i && !redirect_i;
    assign w_stall  = rstn_i && !redirect_i && !w_credit;

    // Saturating counters of delivered instructions and stalled cycles.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            perf_instr_o <= '0;
            perf_stall_o <= '0;
        end else begin
            if (w_accept && perf_instr_o != 32'hFFFF_FFFF)
                perf_instr_o <= perf_instr_o + 32'd1;
            if (w_stall && perf_stall_o != 32'hFFFF_FFFF)
                perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a PC register and 1-cycle byte memory.
// Covers linear fetch, backpressure, redirects, address wrap and async reset.
module tb_fetch_unit;
    import nes_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] pc;
    logic        taken_branch;
    logic [15:0] new_pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        valid;
    logic        ready;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  len;
    logic [15:0] ipc;

    logic [7:0]  mem [0:65535];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .pc_i            (pc),
        .taken_branch_o  (taken_branch),
        .new_pc_o        (new_pc),
        .mem_req_o       (mem_req),
        .mem_addr_o      (mem_addr),
        .mem_rdata_i     (rdata),
        .redirect_i      (redirect),
        .redirect_pc_i   (redirect_pc),
        .instr_valid_o   (valid),
        .instr_ready_i   (ready),
        .instr_opcode_o  (opcode),
        .instr_operand_o (operand),
        .instr_len_o     (len),
        .instr_pc_o      (ipc)
    );

    // PC register: load on taken_branch, otherwise advance by one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            pc <= 16'h0200;
        else if (taken_branch)
            pc <= new_pc;
        else
            pc <= pc + 16'd1;
    end

    // Instruction memory with one cycle of read latency.
    always_ff @(posedge clk) begin
        if (mem_req)
            rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_instr(input string tag, input logic [7:0] eo,
                              input logic [15:0] eop, input logic [1:0] el,
                              input logic [15:0] epc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid && n < 60);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_opc"}, 32'(opcode), 32'(eo));
        chk({tag, "_opnd"}, 32'(operand), 32'(eop));
        chk({tag, "_len"}, 32'(len), 32'(el));
        chk({tag, "_pc"}, 32'(ipc), 32'(epc));
    endtask

    task automatic do_redirect(input logic [15:0] addr);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = addr;
        @(negedge clk);
        redirect    = 1'b0;
    endtask

    initial begin
        int          stall_bad;
        int          unstable;
        int          n;
        logic [42:0] snap;

        for (int i = 0; i < 65536; i++)
            mem[i] = 8'hEA;
        mem[16'h0200] = 8'hEA; mem[16'h0201] = 8'hA9;
        mem[16'h0202] = 8'h05; mem[16'h0203] = 8'h4C;
        mem[16'h0204] = 8'h00; mem[16'h0205] = 8'h03;
        mem[16'h0500] = 8'hA9; mem[16'h0501] = 8'h11;
        mem[16'h0502] = 8'hA9; mem[16'h0503] = 8'h22;
        mem[16'h0504] = 8'hA9; mem[16'h0505] = 8'h33;
        mem[16'h0506] = 8'hA9; mem[16'h0507] = 8'h44;
        mem[16'h0400] = 8'h20; mem[16'h0401] = 8'h34;
        mem[16'h0402] = 8'h12;
        mem[16'h9000] = 8'h4C;
        mem[16'h9100] = 8'hA2; mem[16'h9101] = 8'h77;
        mem[16'hFFFF] = 8'h4C;
        mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;

        rstn        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        ready       = 1'b1;

        #12;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_taken", 32'(taken_branch), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_newpc", 32'(new_pc), 32'd0);
        chk("rst_opc", 32'(opcode), 32'd0);
        chk("rst_opnd", 32'(operand), 32'd0);
        chk("rst_len", 32'(len), 32'd0);
        chk("rst_ipc", 32'(ipc), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        wait_instr("lin0", 8'hEA, 16'h0000, 2'd1, 16'h0200);
        wait_instr("lin1", 8'hA9, 16'h0005, 2'd2, 16'h0201);
        wait_instr("lin2", 8'h4C, 16'h0300, 2'd3, 16'h0203);

        ready = 1'b0;
        do_redirect(16'h0500);
        stall_bad = 0;
        unstable  = 0;
        snap      = '0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 9)
                snap = {valid, opcode, operand, len, ipc};
            if (k >= 10) begin
                if (!(taken_branch && new_pc == pc && !mem_req))
                    stall_bad++;
                if ({valid, opcode, operand, len, ipc} != snap)
                    unstable++;
            end
        end
        chk("bp_stall", 32'(stall_bad), 32'd0);
        chk("bp_stable", 32'(unstable), 32'd0);
        chk("bp_count", 32'(dut.u_fifo.count_o), 32'd4);
        chk("bp_pc", 32'(pc), 32'h0506);
        chk("bp_valid", 32'(valid), 32'd1);
        chk("bp_opc", 32'(opcode), 32'h00A9);
        chk("bp_opnd", 32'(operand), 32'h0011);
        chk("bp_ipc", 32'(ipc), 32'h0500);
        ready = 1'b1;
        wait_instr("bp1", 8'hA9, 16'h0022, 2'd2, 16'h0502);
        wait_instr("bp2", 8'hA9, 16'h0033, 2'd2, 16'h0504);
        wait_instr("bp3", 8'hA9, 16'h0044, 2'd2, 16'h0506);

        do_redirect(16'h0400);
        n = 0;
        while (!(dut.r_state == ASM_OP1 && opcode == 8'h20) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rd_reach_op1", 32'(n < 40), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 16'h8000;
        @(negedge clk);
        redirect    = 1'b0;
        chk("rd_valid_low", 32'(valid), 32'd0);
        chk("rd_fifo_empty", 32'(dut.u_fifo.count_o), 32'd0);
        wait_instr("rd", 8'hEA, 16'h0000, 2'd1, 16'h8000);

        do_redirect(16'h9000);
        #1;
        chk("if_req", 32'(mem_req), 32'd1);
        chk("if_addr", 32'(mem_addr), 32'h9000);
        @(negedge clk);
        chk("if_inflight", 32'(dut.r_inflight), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 16'h9100;
        @(negedge clk);
        redirect    = 1'b0;
        #1;
        chk("if_fifo_empty", 32'(dut.u_fifo.count_o), 32'd0);
        chk("if_inflight_clr", 32'(dut.r_inflight), 32'd0);
        chk("if_valid", 32'(valid), 32'd0);
        wait_instr("if", 8'hA2, 16'h0077, 2'd2, 16'h9100);

        do_redirect(16'hFFFF);
        wait_instr("wrap", 8'h4C, 16'h1234, 2'd3, 16'hFFFF);

        ready = 1'b0;
        do_redirect(16'hA000);
        wait_instr("pre_rst", 8'hEA, 16'h0000, 2'd1, 16'hA000);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_taken", 32'(taken_branch), 32'd0);
        chk("arst_req", 32'(mem_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
